// File: rtl/fp32_add_sequencer_if.sv
// Operand/result handshake bundle for the binary32 add/subtract sequencer.
// The sequencer attaches through the slave modport, its requester through master.
interface fp32_add_sequencer_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        sub_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  modport slave (
    input  in_valid_i, op_a_i, op_b_i, sub_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, busy_o
  );

  modport master (
    output in_valid_i, op_a_i, op_b_i, sub_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, busy_o
  );
endinterface

// File: rtl/fp32_add_sequencer.sv
// Fixed-latency multi-cycle binary32 adder/subtractor for the vector unit:
// capture/swap, align, add, normalize and round/pack, one operation in flight.
module fp32_add_sequencer #(
  parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  fp32_add_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t state, state_next;

  logic        big_sign, both_neg, eff_sub, spec_hit, zero;
  logic [7:0]  big_exp, diff;
  logic [23:0] big_sig, small_sig;
  logic [31:0] spec_res, result_q;
  logic [26:0] aligned, norm_sig;
  logic [27:0] sum;
  logic [9:0]  norm_exp;

  logic        sign_a, sign_b_eff, swap;
  logic [7:0]  exp_a, exp_b, e_a, e_b;
  logic [22:0] man_a, man_b;
  logic [23:0] sig_a, sig_b;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        spec_hit_next;
  logic [31:0] spec_res_next;

  assign sign_a     = bus.op_a_i[31];
  assign sign_b_eff = bus.op_b_i[31] ^ bus.sub_i;
  assign exp_a      = bus.op_a_i[30:23];
  assign exp_b      = bus.op_b_i[30:23];
  assign man_a      = bus.op_a_i[22:0];
  assign man_b      = bus.op_b_i[22:0];
  assign e_a        = (exp_a == 8'd0) ? 8'd1 : exp_a;
  assign e_b        = (exp_b == 8'd0) ? 8'd1 : exp_b;
  assign sig_a      = {exp_a != 8'd0, man_a};
  assign sig_b      = {exp_b != 8'd0, man_b};
  assign swap       = bus.op_b_i[30:0] > bus.op_a_i[30:0];
  assign nan_a      = (exp_a == 8'hFF) && (man_a != 23'd0);
  assign nan_b      = (exp_b == 8'hFF) && (man_b != 23'd0);
  assign inf_a      = (exp_a == 8'hFF) && (man_a == 23'd0);
  assign inf_b      = (exp_b == 8'hFF) && (man_b == 23'd0);

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = (state == DONE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.result_o    = result_q;

  always_comb begin
    spec_hit_next = 1'b1;
    spec_res_next = NAN_CANON;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b_eff))) begin
      spec_res_next = NAN_CANON;
    end else if (inf_a) begin
      spec_res_next = {sign_a, 8'hFF, 23'd0};
    end else if (inf_b) begin
      spec_res_next = {sign_b_eff, 8'hFF, 23'd0};
    end else begin
      spec_hit_next = 1'b0;
      spec_res_next = 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid_i) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shifted-out bits collapse into the sticky position so rounding sees them.
  logic [26:0] small_ext, shifted, lost_mask, aligned_next;
  always_comb begin
    small_ext    = {small_sig, 3'b000};
    shifted      = '0;
    lost_mask    = '0;
    aligned_next = '0;
    if (diff >= 8'd26) begin
      aligned_next = {26'd0, |small_sig};
    end else begin
      shifted      = small_ext >> diff;
      lost_mask    = (27'd1 << diff) - 27'd1;
      aligned_next = {shifted[26:1], shifted[0] | (|(small_ext & lost_mask))};
    end
  end

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // Left shift stops at exponent 1 so tiny results land as denormals.
  logic [4:0]  lz;
  logic [7:0]  limit, shamt;
  logic [26:0] norm_sig_next;
  logic [9:0]  norm_exp_next;
  always_comb begin
    lz            = lzc27(sum[26:0]);
    limit         = big_exp - 8'd1;
    shamt         = ({3'b000, lz} > limit) ? limit : {3'b000, lz};
    norm_sig_next = '0;
    norm_exp_next = '0;
    if (sum[27]) begin
      norm_sig_next = {sum[27:2], sum[1] | sum[0]};
      norm_exp_next = {2'b00, big_exp} + 10'd1;
    end else begin
      norm_sig_next = sum[26:0] << shamt;
      norm_exp_next = {2'b00, big_exp} - {2'b00, shamt};
    end
  end

  logic        round_up, hid;
  logic [24:0] rounded;
  logic [9:0]  exp_r;
  logic [22:0] frac;
  logic [31:0] packed_res;
  always_comb begin
    round_up   = norm_sig[2] & (norm_sig[1] | norm_sig[0] | norm_sig[3]);
    rounded    = {1'b0, norm_sig[26:3]} + {24'd0, round_up};
    exp_r      = norm_exp + {9'd0, rounded[24]};
    frac       = rounded[24] ? 23'd0 : rounded[22:0];
    hid        = rounded[24] | rounded[23];
    packed_res = {big_sign, (hid ? exp_r[7:0] : 8'd0), frac};
    if (spec_hit) begin
      packed_res = spec_res;
    end else if (zero) begin
      packed_res = {both_neg, 31'd0};
    end else if (exp_r >= 10'd255) begin
      packed_res = {big_sign, 8'hFF, 23'd0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      big_sign  <= 1'b0;
      both_neg  <= 1'b0;
      eff_sub   <= 1'b0;
      spec_hit  <= 1'b0;
      spec_res  <= '0;
      big_exp   <= '0;
      diff      <= '0;
      big_sig   <= '0;
      small_sig <= '0;
      aligned   <= '0;
      sum       <= '0;
      norm_sig  <= '0;
      norm_exp  <= '0;
      zero      <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid_i) begin
          big_sign  <= swap ? sign_b_eff : sign_a;
          big_exp   <= swap ? e_b : e_a;
          big_sig   <= swap ? sig_b : sig_a;
          small_sig <= swap ? sig_a : sig_b;
          diff      <= swap ? (e_b - e_a) : (e_a - e_b);
          eff_sub   <= sign_a ^ sign_b_eff;
          both_neg  <= sign_a & sign_b_eff;
          spec_hit  <= spec_hit_next;
          spec_res  <= spec_res_next;
        end
        ALIGN: aligned <= aligned_next;
        ADD: sum <= eff_sub ? ({1'b0, big_sig, 3'b000} - {1'b0, aligned})
                            : ({1'b0, big_sig, 3'b000} + {1'b0, aligned});
        NORM: begin
          norm_sig <= norm_sig_next;
          norm_exp <= norm_exp_next;
          zero     <= (sum == 28'd0);
        end
        ROUND: result_q <= packed_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_add_sequencer.sv
// Randomized and directed checks of fp32_add_sequencer against an exact
// wide-integer reference of binary32 addition with round-to-nearest-even.
module tb_fp32_add_sequencer;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checkCount = 0;
  int   passCount = 0;

  fp32_add_sequencer_if bus();

  fp32_add_sequencer #(.NAN_CANON(32'h7FC00000)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Operands become exact integers in units of 2^-149; the sum is then rounded once.
  function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic         sa, sb, sign;
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic [299:0] ma, mb, mag, mant, rem, half, one;
    int           p, shift, e;
    sa = a[31]; sb = b[31] ^ sub;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC00000;
    if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? {sa, 31'h7F800000} : 32'h7FC00000;
    if (ea == 8'hFF) return {sa, 31'h7F800000};
    if (eb == 8'hFF) return {sb, 31'h7F800000};
    one = 300'd1;
    ma = (ea == 0) ? 300'(fa) : (300'({1'b1, fa}) << (ea - 1));
    mb = (eb == 0) ? 300'(fb) : (300'({1'b1, fb}) << (eb - 1));
    if (sa == sb)      begin mag = ma + mb; sign = sa; end
    else if (ma >= mb) begin mag = ma - mb; sign = sa; end
    else               begin mag = mb - ma; sign = sb; end
    if (mag == 0) return {sa & sb, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p <= 23) return {sign, (mag[23] ? 8'd1 : 8'd0), mag[22:0]};
    shift = p - 23;
    mant  = mag >> shift;
    rem   = mag & ((one << shift) - one);
    half  = one << (shift - 1);
    if (rem > half || (rem == half && mant[0])) mant = mant + one;
    if (mant[24]) begin mant = mant >> 1; shift++; end
    e = shift + 1;
    if (e >= 255) return {sign, 31'h7F800000};
    return {sign, 8'(e), mant[22:0]};
  endfunction

  task automatic waitReady();
    int waitCycles = 0;
    while (!bus.in_ready_o && waitCycles < 20) begin
      @(posedge clk_i); #1;
      waitCycles++;
    end
    checkOutput("in_ready_wait", {31'd0, bus.in_ready_o}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input int holdCycles, input bit fullCheck);
    logic [31:0] expected;
    int          latency;
    expected = refAdd(a, b, sub);
    waitReady();
    bus.op_a_i = a; bus.op_b_i = b; bus.sub_i = sub;
    bus.out_ready_i = (holdCycles == 0);
    bus.in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    bus.op_a_i = $urandom; bus.op_b_i = $urandom; bus.sub_i = ~sub;
    latency = 0;
    while (!bus.out_valid_o && latency < 20) begin
      @(posedge clk_i); #1;
      latency++;
    end
    checkOutput("latency", 32'(latency), 32'd4);
    checkOutput($sformatf("result %08h%s%08h", a, sub ? "-" : "+", b), bus.result_o, expected);
    if (holdCycles > 0) begin
      bus.in_valid_i = 1'b1;
      for (int i = 0; i < holdCycles; i++) begin
        @(posedge clk_i); #1;
        checkOutput("hold_out_valid", {31'd0, bus.out_valid_o}, 32'd1);
        checkOutput("hold_result", bus.result_o, expected);
        checkOutput("hold_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
      end
      bus.in_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
    end
    @(posedge clk_i); #1;
    if (fullCheck) begin
      checkOutput("post_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
      checkOutput("post_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
      checkOutput("post_result_kept", bus.result_o, expected);
    end
  endtask

  task automatic resetMidOp(input logic [31:0] a, input logic [31:0] b);
    int sawValid = 0;
    waitReady();
    bus.op_a_i = a; bus.op_b_i = b; bus.sub_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    checkOutput("midrst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    checkOutput("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("midrst_result", bus.result_o, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (bus.out_valid_o) sawValid++;
    end
    checkOutput("midrst_no_output", 32'(sawValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic        sub;
    rst_ni = 1'b0;
    bus.in_valid_i = 1'b0; bus.op_a_i = '0; bus.op_b_i = '0;
    bus.sub_i = 1'b0; bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    checkOutput("reset_in_ready", {31'd0, bus.in_ready_o}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    checkOutput("reset_result", bus.result_o, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy_o}, 32'd0);

    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 0, 1'b1);
    checkOutput("known_3p0", bus.result_o, 32'h40400000);
    applyStimulus(32'h3F800000, 32'h40400000, 1'b1, 0, 1'b1);
    checkOutput("known_m2p0", bus.result_o, 32'hC0000000);
    applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 0, 1'b1);
    applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 0, 1'b1);
    applyStimulus(32'h3F800000, 32'h33800001, 1'b0, 0, 1'b1);
    checkOutput("known_sticky_up", bus.result_o, 32'h3F800001);
    applyStimulus(32'h3F800000, 32'h0C800000, 1'b0, 0, 1'b1);
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, 1'b1);
    applyStimulus(32'h7F800000, 32'h7F800000, 1'b1, 0, 1'b1);
    applyStimulus(32'h00000001, 32'h00000001, 1'b0, 0, 1'b1);
    checkOutput("known_denorm", bus.result_o, 32'h00000002);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 0, 1'b1);
    applyStimulus(32'hFF800000, 32'h3F800000, 1'b0, 0, 1'b1);
    applyStimulus(32'h3F800000, 32'h7FA00000, 1'b0, 0, 1'b1);
    applyStimulus(32'h40A00000, 32'hC0400000, 1'b0, 3, 1'b1);

    resetMidOp(32'h40A00000, 32'h3F800000);
    applyStimulus(32'h40A00000, 32'h3F800000, 1'b0, 0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        1: b[30:23] = a[30:23] ^ 8'($urandom_range(0, 3));
        2: begin
          a[30:23] = 8'($urandom_range(0, 2));
          b[30:23] = 8'($urandom_range(0, 2));
        end
        3: b[30:0] = a[30:0];
        default: ;
      endcase
      applyStimulus(a, b, sub, (n % 17 == 0) ? 2 : 0, (n % 5 == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
